// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback source requests plus the regfile write port they are funnelled into.
interface regfile_wb_arbiter_if #(
    parameter int NUM_SRC = 3
);
    localparam int GW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    logic [NUM_SRC-1:0]    src_valid;
    logic [NUM_SRC-1:0]    src_ready;
    logic [NUM_SRC*5-1:0]  src_addr;
    logic [NUM_SRC*32-1:0] src_data;
    logic                  w_enable;
    logic [4:0]            w_addr;
    logic [31:0]           w_data;
    logic [GW-1:0]         grant_id;
    logic [NUM_SRC-1:0]    starve;
    modport master (
        output src_valid, src_addr, src_data,
        input  src_ready, w_enable, w_addr, w_data, grant_id, starve
    );
    modport slave (
        input  src_valid, src_addr, src_data,
        output src_ready, w_enable, w_addr, w_data, grant_id, starve
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: picks one writeback source per cycle for the regfile write port,
// round-robin or fixed priority, with starving sources promoted above the rest.
module regfile_wb_arbiter #(
    parameter int NUM_SRC   = 3,
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4
) (
    input logic clk,
    input logic rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int GW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [GW-1:0]      rr_ptr, base, off, win;
    logic [GW:0]        sum;
    logic [WW-1:0]      wait_cnt [NUM_SRC];
    logic [NUM_SRC-1:0] starving, cand, rot;
    logic               found;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) starving[i] = wait_cnt[i] == WW'(MAX_WAIT);
        cand = |(bus.src_valid & starving) ? bus.src_valid & starving : bus.src_valid;
        base = PRIO_MODE != 0 ? '0 : rr_ptr;
        // Rotate so bit k is the candidate k places after the scan start.
        rot = NUM_SRC'({cand, cand} >> base);
        found = 1'b0;
        off = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                off = GW'(k);
            end
        end
        sum = {1'b0, base} + {1'b0, off};
        win = sum >= (GW+1)'(NUM_SRC) ? GW'(sum - (GW+1)'(NUM_SRC)) : GW'(sum);
        bus.src_ready = (rst || !found) ? '0 : NUM_SRC'(1) << win;
        bus.starve = starving;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.w_enable <= 1'b0;
            bus.w_addr   <= '0;
            bus.w_data   <= '0;
            bus.grant_id <= '0;
            rr_ptr       <= '0;
            for (int i = 0; i < NUM_SRC; i++) wait_cnt[i] <= '0;
        end else begin
            // A grant to x0 still completes the handshake but never writes.
            bus.w_enable <= found && bus.src_addr[win*5 +: 5] != 5'd0;
            if (found) begin
                bus.w_addr   <= bus.src_addr[win*5 +: 5];
                bus.w_data   <= bus.src_data[win*32 +: 32];
                bus.grant_id <= win;
                rr_ptr       <= win == GW'(NUM_SRC - 1) ? '0 : win + 1'b1;
            end
            for (int i = 0; i < NUM_SRC; i++)
                wait_cnt[i] <= (bus.src_valid[i] && !bus.src_ready[i]) ?
                               (starving[i] ? wait_cnt[i] : wait_cnt[i] + 1'b1) : '0;
        end
    end

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_proto
        assert property (@(posedge clk) disable iff (rst)
            bus.src_valid[g] && !bus.src_ready[g] |=> bus.src_valid[g] &&
            $stable(bus.src_addr[g*5 +: 5]) && $stable(bus.src_data[g*32 +: 32]));
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: round-robin and fixed-priority arbiters checked against
// constant vectors, hand-built corner sequences and a queue-free behavioural model.
module tb_regfile_wb_arbiter;
    localparam int N  = 3;
    localparam int MW = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NUM_SRC(N)) bus0 ();
    regfile_wb_arbiter_if #(.NUM_SRC(N)) bus1 ();
    regfile_wb_arbiter #(.NUM_SRC(N), .PRIO_MODE(0), .MAX_WAIT(MW)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    regfile_wb_arbiter #(.NUM_SRC(N), .PRIO_MODE(1), .MAX_WAIT(MW)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    logic [N-1:0]    sv [2];
    logic [N*5-1:0]  sa [2];
    logic [N*32-1:0] sd [2];
    assign bus0.src_valid = sv[0];
    assign bus0.src_addr  = sa[0];
    assign bus0.src_data  = sd[0];
    assign bus1.src_valid = sv[1];
    assign bus1.src_addr  = sa[1];
    assign bus1.src_data  = sd[1];

    logic [N-1:0] rdy_w [2], st_w [2];
    logic         we_w  [2];
    logic [4:0]   wa_w  [2];
    logic [31:0]  wd_w  [2];
    logic [1:0]   gid_w [2];
    assign rdy_w[0] = bus0.src_ready;
    assign rdy_w[1] = bus1.src_ready;
    assign st_w[0]  = bus0.starve;
    assign st_w[1]  = bus1.starve;
    assign we_w[0]  = bus0.w_enable;
    assign we_w[1]  = bus1.w_enable;
    assign wa_w[0]  = bus0.w_addr;
    assign wa_w[1]  = bus1.w_addr;
    assign wd_w[0]  = bus0.w_data;
    assign wd_w[1]  = bus1.w_data;
    assign gid_w[0] = bus0.grant_id;
    assign gid_w[1] = bus1.grant_id;

    int checks = 0;
    int errors = 0;

    // Reference model: per-source waiting time, next scan start, and the expected write port.
    int          wcnt [2][N];
    int          ptr [2];
    int          lastwin [2];
    logic        exp_we [2];
    logic [4:0]  exp_wa [2];
    logic [31:0] exp_wd [2];
    int          exp_gid [2];
    logic [N-1:0] rdy_s [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_win(input int d);
        logic [N-1:0] c;
        int i;
        c = '0;
        for (int j = 0; j < N; j++) if (sv[d][j] && wcnt[d][j] == MW) c[j] = 1'b1;
        if (c == '0) c = sv[d];
        for (int k = 0; k < N; k++) begin
            i = (d == 1) ? k : (ptr[d] + k) % N;
            if (c[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_starve(input int d);
        logic [N-1:0] s;
        for (int j = 0; j < N; j++) s[j] = wcnt[d][j] == MW;
        return s;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            ptr[d] = 0;
            lastwin[d] = -1;
            exp_we[d] = 1'b0;
            exp_wa[d] = '0;
            exp_wd[d] = '0;
            exp_gid[d] = 0;
            for (int j = 0; j < N; j++) wcnt[d][j] = 0;
        end
    endtask

    task automatic model_commit(input int d);
        int w;
        w = model_win(d);
        lastwin[d] = w;
        if (w >= 0) begin
            exp_we[d] = sa[d][w*5 +: 5] != 5'd0;
            exp_wa[d] = sa[d][w*5 +: 5];
            exp_wd[d] = sd[d][w*32 +: 32];
            exp_gid[d] = w;
            ptr[d] = (w + 1) % N;
        end else begin
            exp_we[d] = 1'b0;
        end
        for (int j = 0; j < N; j++)
            wcnt[d][j] = (sv[d][j] && j != w) ? (wcnt[d][j] < MW ? wcnt[d][j] + 1 : MW) : 0;
    endtask

    // Called at posedge+1 with inputs settled; checks both DUTs across one edge.
    task automatic cyc();
        int w;
        #3;
        for (int d = 0; d < 2; d++) begin
            w = model_win(d);
            rdy_s[d] = rdy_w[d];
            chk($sformatf("ready%0d", d), 32'(rdy_w[d]), w >= 0 ? 32'(1) << w : 32'd0);
            chk($sformatf("starve%0d", d), 32'(st_w[d]), 32'(model_starve(d)));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_commit(d);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("w_enable%0d", d), 32'(we_w[d]), 32'(exp_we[d]));
            chk($sformatf("grant_id%0d", d), 32'(gid_w[d]), 32'(exp_gid[d]));
            if (exp_we[d]) begin
                chk($sformatf("w_addr%0d", d), 32'(wa_w[d]), 32'(exp_wa[d]));
                chk($sformatf("w_data%0d", d), wd_w[d], exp_wd[d]);
            end
        end
    endtask

    task automatic new_req(input int d);
        for (int j = 0; j < N; j++) begin
            if (!sv[d][j] || lastwin[d] == j) begin
                sv[d][j] = $urandom_range(0, 2) != 0;
                sa[d][j*5 +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                sd[d][j*32 +: 32] = $urandom;
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_w_enable%0d", tag, d), 32'(we_w[d]), 32'd0);
            chk($sformatf("%s_ready%0d", tag, d), 32'(rdy_w[d]), 32'd0);
            chk($sformatf("%s_w_addr%0d", tag, d), 32'(wa_w[d]), 32'd0);
            chk($sformatf("%s_w_data%0d", tag, d), wd_w[d], 32'd0);
            chk($sformatf("%s_grant_id%0d", tag, d), 32'(gid_w[d]), 32'd0);
        end
    endtask

    typedef struct {
        logic [N-1:0]    v;
        logic [N*5-1:0]  a;
        logic [N*32-1:0] dt;
        logic [N-1:0]    rdy;
        logic            we;
        logic [4:0]      wa;
        logic [31:0]     wd;
        logic [1:0]      gid;
        logic            cw;
    } vec_t;
    vec_t tbl [13];

    localparam logic [14:0] RR_A = {5'd3, 5'd2, 5'd1};
    localparam logic [95:0] RR_D = {32'hC0C0_0002, 32'hB0B0_0001, 32'hA0A0_0000};

    initial begin
        tbl[0]  = '{3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0}, 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1, 1'b1};
        tbl[1]  = '{3'b000, 15'd0, 96'd0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd1, 1'b1};
        tbl[2]  = '{3'b001, 15'd0, {64'h0, 32'h0000_1234}, 3'b001, 1'b0, 5'd0, 32'h0, 2'd0, 1'b0};
        tbl[3]  = '{3'b001, {10'd0, 5'd7}, {64'h0, 32'h0000_0077}, 3'b001, 1'b1, 5'd7, 32'h77, 2'd0, 1'b1};
        tbl[4]  = '{3'b100, RR_A, RR_D, 3'b100, 1'b1, 5'd3, 32'hC0C0_0002, 2'd2, 1'b1};
        for (int t = 0; t < 6; t++)
            tbl[5+t] = '{3'b111, RR_A, RR_D, 3'(1 << (t % 3)), 1'b1, 5'(t % 3 + 1),
                         RR_D[(t%3)*32 +: 32], 2'(t % 3), 1'b1};
        tbl[11] = '{3'b011, RR_A, RR_D, 3'b001, 1'b1, 5'd1, 32'hA0A0_0000, 2'd0, 1'b1};
        tbl[12] = '{3'b010, RR_A, RR_D, 3'b010, 1'b1, 5'd2, 32'hB0B0_0001, 2'd1, 1'b1};

        for (int d = 0; d < 2; d++) begin
            sv[d] = '0;
            sa[d] = '0;
            sd[d] = '0;
        end
        model_reset();
        #1;
        chk_reset("por");
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 13; t++) begin
            sv[0] = tbl[t].v;
            sa[0] = tbl[t].a;
            sd[0] = tbl[t].dt;
            cyc();
            chk($sformatf("tbl%0d_ready", t), 32'(rdy_s[0]), 32'(tbl[t].rdy));
            chk($sformatf("tbl%0d_w_enable", t), 32'(we_w[0]), 32'(tbl[t].we));
            chk($sformatf("tbl%0d_grant_id", t), 32'(gid_w[0]), 32'(tbl[t].gid));
            if (tbl[t].cw) begin
                chk($sformatf("tbl%0d_w_addr", t), 32'(wa_w[0]), 32'(tbl[t].wa));
                chk($sformatf("tbl%0d_w_data", t), wd_w[0], tbl[t].wd);
            end
        end
        sv[0] = '0;

        // Fixed priority: src2 starves behind src0, then is promoted.
        sv[1] = 3'b101;
        sa[1] = {5'd12, 5'd0, 5'd10};
        sd[1] = {32'h2222_2222, 32'h0, 32'h1000_0000};
        for (int c = 1; c <= 4; c++) begin
            cyc();
            chk($sformatf("starve_c%0d_ready", c), 32'(rdy_s[1]), 32'b001);
            chk($sformatf("starve_c%0d_grant", c), 32'(gid_w[1]), 32'd0);
            sd[1][31:0] = 32'h1000_0000 + 32'(c);
        end
        chk("starve_flag", 32'(st_w[1]), 32'b100);
        cyc();
        chk("starve_promote_ready", 32'(rdy_s[1]), 32'b100);
        chk("starve_promote_grant", 32'(gid_w[1]), 32'd2);
        chk("starve_promote_addr", 32'(wa_w[1]), 32'd12);
        chk("starve_cleared", 32'(st_w[1][2]), 32'd0);
        sv[1] = 3'b001;
        cyc();
        sv[1] = '0;
        cyc();

        for (int c = 0; c < 400; c++) begin
            new_req(0);
            new_req(1);
            cyc();
        end

        // Asynchronous reset mid-cycle with every source requesting.
        sv[0] = '1;
        sv[1] = '1;
        cyc();
        #2 rst = 1'b1;
        #1;
        chk_reset("async");
        sv[0] = '0;
        sv[1] = '0;
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset lands while a write to x9 sits on the port.
        sa[0] = {10'd0, 5'd9};
        sd[0] = {64'h0, 32'h0909_0909};
        sv[0] = 3'b001;
        cyc();
        chk("traffic_w_addr", 32'(wa_w[0]), 32'd9);
        chk("traffic_w_enable", 32'(we_w[0]), 32'd1);
        sv[0] = '0;
        #2 rst = 1'b1;
        #1;
        chk("traffic_drop", 32'(we_w[0]), 32'd0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk($sformatf("no_write9_c%0d", c), 32'(we_w[0]), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
